// File: rtl/seg7_pkg.sv
// Shared types, constants and the hex-to-segment table for the 4-digit
// seven-segment scan driver.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd1,
        ON   = 2'd2
    } state_t;

    localparam logic [3:0] ANODE_OFF = 4'b1111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; element 0 is the rightmost entry.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [3:0] anode_onehot_low(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode display driver with per-slot dead
// time; inputs are captured once at each slot entry so a digit never glitches.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DEAD_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_sel,
    output logic        scan_tick
);

    localparam int unsigned    CNT_W      = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD_CYCLES == 0) ? 0 : DEAD_CYCLES - 1);
    localparam state_t         SLOT_START = (DEAD_CYCLES == 0) ? ON : DEAD;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             blank_q, blank_d;
    logic [3:0]       anode_q;
    logic [6:0]       seg_q;
    logic             dp_q;
    logic [1:0]       sel_q;
    logic             tick_q;
    logic             entry;
    logic             wrap;
    logic [3:0]       nibble;
    logic [6:0]       dec_seg;

    assign nibble = digits[{idx_d, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .hex_i (nibble),
        .seg_o (dec_seg)
    );

    // Slot sequencing: counter, slot index and phase for the coming cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        entry   = 1'b0;
        wrap    = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SLOT_START;
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                    entry   = 1'b1;
                end
                default: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = SLOT_START;
                        cnt_d   = '0;
                        idx_d   = idx_q + 2'd1;
                        entry   = 1'b1;
                        wrap    = (idx_q == 2'd3);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (state_q == DEAD && DEAD_CYCLES != 0 && cnt_q == DEAD_LAST) begin
                            state_d = ON;
                        end
                    end
                end
            endcase
        end
    end

    assign blank_d = entry ? blank[idx_d] : blank_q;

    // State and registered display outputs; seg/dp only reload at slot entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            blank_q <= 1'b0;
            anode_q <= ANODE_OFF;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
            sel_q   <= 2'd0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            blank_q <= blank_d;
            sel_q   <= idx_d;
            tick_q  <= wrap;
            if (state_d == IDLE) begin
                anode_q <= ANODE_OFF;
                seg_q   <= SEG_BLANK;
                dp_q    <= 1'b1;
            end else begin
                anode_q <= (state_d == ON && !blank_d) ? anode_onehot_low(idx_d) : ANODE_OFF;
                if (entry) begin
                    seg_q <= blank_d ? SEG_BLANK : dec_seg;
                    dp_q  <= blank_d | ~dp_in[idx_d];
                end
            end
        end
    end

    assign anode     = anode_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign digit_sel = sel_q;
    assign scan_tick = tick_q;

endmodule
